// File: rtl/int_pkg.sv
// Shared definitions for the interrupt request unit: FSM encoding, default
// line count and vector base, and the source-id type used to tag the winner.
package int_pkg;

    localparam int NUM_LINES_DEF = 8;
    localparam logic [7:0] HW_VEC_BASE_DEF = 8'h20;

    // Source id: hardware lines use their index 0..NUM_LINES-1; the all-ones
    // code marks the software slot, so the width must leave room for it.
    localparam int SRC_ID_W = $clog2(NUM_LINES_DEF + 1);
    typedef logic [SRC_ID_W-1:0] src_id_t;
    localparam src_id_t SRC_SW = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder: lowest-numbered set bit wins.
module int_prio_enc #(
    parameter int N = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    output logic             any,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest eligible index is the last write.
    always_comb begin
        any   = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_reg.sv
// Generic enabled register with asynchronous active-high reset.
module int_reg #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; reset forces the reset value immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/int_request_unit.sv
// Interrupt request unit: edge-detects hardware lines, buffers one software
// INT n request, picks a winner and holds it armed until int_controller
// reports it serviced, then inserts one idle gap cycle.
module int_request_unit
    import int_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter logic [7:0] HW_VEC_BASE = HW_VEC_BASE_DEF,
    parameter logic [31:0] IDT_BASE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LINES-1:0] int_lines,
    input  logic [NUM_LINES-1:0] line_mask,
    input  logic                 if_flag,
    input  logic                 sw_int_valid,
    input  logic [7:0]           sw_int_vector,
    output logic                 sw_int_ready,
    input  logic                 int_clear,
    output logic                 or_int_vec,
    output logic [7:0]           int_vector,
    output logic [31:0]          idt_address,
    output logic [NUM_LINES-1:0] pending
);

    localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic [NUM_LINES-1:0] prev_lines;
    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] pending_next;
    logic [NUM_LINES-1:0] hw_clear;
    logic [NUM_LINES-1:0] hw_eligible;

    logic                 sw_pending;
    logic                 sw_pending_next;
    logic                 sw_accept;
    logic [7:0]           sw_vector;

    logic [1:0]           state;
    state_t               state_next;

    src_id_t              cap_src;
    src_id_t              cap_src_next;
    logic [7:0]           cap_vector;
    logic [7:0]           cap_vector_next;

    logic                 any_hw;
    logic [LINE_W-1:0]    hw_index;
    logic                 any_req;
    logic                 capture_en;
    logic                 clear_en;
    logic                 armed;

    // ---------------- hardware line edge detect and pending bits ----------
    // prev_lines resets to all ones so a line held high across reset release
    // is not mistaken for a fresh edge.
    int_reg #(.W(NUM_LINES), .RST_VAL({NUM_LINES{1'b1}})) u_prev (
        .clk(clk), .reset(reset), .en(1'b1), .d(int_lines), .q(prev_lines)
    );

    assign rise = int_lines & ~prev_lines;

    // Clear only the captured hardware source; a new edge on the same cycle wins.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            assign hw_clear[gi]     = clear_en && (cap_src == SRC_ID_W'(gi));
            assign pending_next[gi] = rise[gi] | (pending[gi] & ~hw_clear[gi]);
            assign hw_eligible[gi]  = pending[gi] & ~line_mask[gi] & if_flag;
        end
    endgenerate

    int_reg #(.W(NUM_LINES)) u_pending (
        .clk(clk), .reset(reset), .en(1'b1), .d(pending_next), .q(pending)
    );

    // ---------------- software slot ---------------------------------------
    // Ready comes from the registered flag, so a slot freed by int_clear
    // cannot accept a new request in that same cycle.
    assign sw_int_ready    = ~sw_pending;
    assign sw_accept       = sw_int_valid & ~sw_pending;
    assign sw_pending_next = sw_accept | (sw_pending & ~(clear_en && (cap_src == SRC_SW)));

    int_reg #(.W(1)) u_sw_pending (
        .clk(clk), .reset(reset), .en(1'b1), .d(sw_pending_next), .q(sw_pending)
    );

    int_reg #(.W(8)) u_sw_vector (
        .clk(clk), .reset(reset), .en(sw_accept), .d(sw_int_vector), .q(sw_vector)
    );

    // ---------------- arbitration -----------------------------------------
    int_prio_enc #(.N(NUM_LINES), .IDX_W(LINE_W)) u_prio (
        .eligible(hw_eligible),
        .any(any_hw),
        .index(hw_index)
    );

    // Software slot outranks every hardware line.
    assign any_req         = sw_pending | any_hw;
    assign cap_src_next    = sw_pending ? SRC_SW : SRC_ID_W'(hw_index);
    assign cap_vector_next = sw_pending ? sw_vector : HW_VEC_BASE + 8'(hw_index);

    int_reg #(.W(SRC_ID_W)) u_cap_src (
        .clk(clk), .reset(reset), .en(capture_en), .d(cap_src_next), .q(cap_src)
    );

    int_reg #(.W(8)) u_cap_vector (
        .clk(clk), .reset(reset), .en(capture_en), .d(cap_vector_next), .q(cap_vector)
    );

    // ---------------- FSM --------------------------------------------------
    // State register.
    int_reg #(.W(2), .RST_VAL(ST_IDLE)) u_state (
        .clk(clk), .reset(reset), .en(1'b1), .d(state_next), .q(state)
    );

    // Next-state logic; the unused encoding recovers to IDLE.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE:  state_next = any_req ? ST_ARMED : ST_IDLE;
            ST_ARMED: state_next = int_clear ? ST_GAP : ST_ARMED;
            ST_GAP:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode: arm/capture in IDLE, service-clear only while ARMED.
    always_comb begin
        armed      = 1'b0;
        capture_en = 1'b0;
        clear_en   = 1'b0;
        case (state)
            ST_IDLE:  capture_en = any_req;
            ST_ARMED: begin
                armed    = 1'b1;
                clear_en = int_clear;
            end
            default: ;
        endcase
    end

    assign or_int_vec  = armed;
    assign int_vector  = cap_vector;
    assign idt_address = IDT_BASE + {21'd0, cap_vector, 3'd0};

endmodule

// File: tb/tb_int_request_unit.sv
// Directed testbench for int_request_unit with hand-computed expectations.
module tb_int_request_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  int_lines;
    logic [7:0]  line_mask;
    logic        if_flag;
    logic        sw_int_valid;
    logic [7:0]  sw_int_vector;
    logic        sw_int_ready;
    logic        int_clear;
    logic        or_int_vec;
    logic [7:0]  int_vector;
    logic [31:0] idt_address;
    logic [7:0]  pending;

    int errors = 0;
    int checks = 0;

    int_request_unit #(
        .NUM_LINES(8),
        .HW_VEC_BASE(8'h20),
        .IDT_BASE(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .int_lines(int_lines),
        .line_mask(line_mask),
        .if_flag(if_flag),
        .sw_int_valid(sw_int_valid),
        .sw_int_vector(sw_int_vector),
        .sw_int_ready(sw_int_ready),
        .int_clear(int_clear),
        .or_int_vec(or_int_vec),
        .int_vector(int_vector),
        .idt_address(idt_address),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-20s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset         = 1'b1;
        int_lines     = 8'h00;
        line_mask     = 8'h00;
        if_flag       = 1'b1;
        sw_int_valid  = 1'b0;
        sw_int_vector = 8'h00;
        int_clear     = 1'b0;
        #2;
        chk("rst_or",      32'(or_int_vec),   32'h0);
        chk("rst_vec",     32'(int_vector),   32'h00);
        chk("rst_idt",     idt_address,       32'h0);
        chk("rst_ready",   32'(sw_int_ready), 32'h1);
        chk("rst_pending", 32'(pending),      32'h00);
        step();
        reset = 1'b0;
        step();
        step();
        chk("idle_or", 32'(or_int_vec), 32'h0);

        // Single line 3 pulse: pending after one edge, armed after two.
        int_lines = 8'h08;
        step();
        int_lines = 8'h00;
        chk("l3_pend",  32'(pending),    32'h08);
        chk("l3_or0",   32'(or_int_vec), 32'h0);
        step();
        chk("l3_or1",   32'(or_int_vec), 32'h1);
        chk("l3_vec",   32'(int_vector), 32'h23);
        chk("l3_idt",   idt_address,     32'h118);
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        chk("l3_gap_or", 32'(or_int_vec), 32'h0);
        chk("l3_gap_pd", 32'(pending),    32'h00);
        chk("l3_keepv",  32'(int_vector), 32'h23);
        step();
        chk("l3_idle_or", 32'(or_int_vec), 32'h0);

        // Lines 5 and 2 together: 2 first, then 5 after the gap.
        int_lines = 8'h24;
        step();
        int_lines = 8'h00;
        step();
        chk("l52_vec1", 32'(int_vector), 32'h22);
        chk("l52_or1",  32'(or_int_vec), 32'h1);
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        chk("l52_gap_or", 32'(or_int_vec), 32'h0);
        chk("l52_gap_pd", 32'(pending),    32'h20);
        step();
        chk("l52_idle_or", 32'(or_int_vec), 32'h0);
        step();
        chk("l52_or2",  32'(or_int_vec), 32'h1);
        chk("l52_vec2", 32'(int_vector), 32'h25);
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        step();

        // Software request and line 1 together: software wins.
        int_lines     = 8'h02;
        sw_int_valid  = 1'b1;
        sw_int_vector = 8'h80;
        step();
        int_lines    = 8'h00;
        sw_int_valid = 1'b0;
        chk("sw_ready0", 32'(sw_int_ready), 32'h0);
        chk("sw_pend1",  32'(pending),      32'h02);
        step();
        chk("sw_or",     32'(or_int_vec),   32'h1);
        chk("sw_vec",    32'(int_vector),   32'h80);
        chk("sw_idt",    idt_address,       32'h400);
        chk("sw_ready1", 32'(sw_int_ready), 32'h0);
        if_flag = 1'b0;
        // Request offered on the freeing edge must not be taken.
        sw_int_valid  = 1'b1;
        sw_int_vector = 8'h90;
        int_clear     = 1'b1;
        step();
        int_clear    = 1'b0;
        sw_int_valid = 1'b0;
        chk("sw_gap_rdy", 32'(sw_int_ready), 32'h1);
        step();
        step();
        step();
        chk("if0_or",   32'(or_int_vec), 32'h0);
        chk("if0_pend", 32'(pending),    32'h02);
        chk("if0_rdy",  32'(sw_int_ready), 32'h1);
        if_flag = 1'b1;
        step();
        chk("if1_or",  32'(or_int_vec), 32'h1);
        chk("if1_vec", 32'(int_vector), 32'h21);
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        step();

        // Armed with 0x24: later IF drop and line 0 edge do not disturb it.
        int_lines = 8'h10;
        step();
        int_lines = 8'h00;
        step();
        chk("a24_vec", 32'(int_vector), 32'h24);
        if_flag   = 1'b0;
        int_lines = 8'h01;
        step();
        chk("a24_hold_or",  32'(or_int_vec), 32'h1);
        chk("a24_hold_vec", 32'(int_vector), 32'h24);
        step();
        chk("a24_hold_v2",  32'(int_vector), 32'h24);
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        chk("a24_gap_pd", 32'(pending), 32'h01);
        if_flag = 1'b1;
        step();
        step();
        chk("a20_or",  32'(or_int_vec), 32'h1);
        chk("a20_vec", 32'(int_vector), 32'h20);

        // Asynchronous reset while armed, line 0 held high.
        reset = 1'b1;
        #1;
        chk("arst_or",  32'(or_int_vec), 32'h0);
        chk("arst_vec", 32'(int_vector), 32'h00);
        chk("arst_pd",  32'(pending),    32'h00);
        step();
        reset = 1'b0;
        step();
        step();
        step();
        chk("held_or", 32'(or_int_vec), 32'h0);
        chk("held_pd", 32'(pending),    32'h00);
        int_lines = 8'h00;
        step();
        int_lines = 8'h01;
        step();
        chk("retog_pd", 32'(pending), 32'h01);
        step();
        chk("retog_vec", 32'(int_vector), 32'h20);
        chk("retog_or",  32'(or_int_vec), 32'h1);
        int_lines = 8'h00;
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        step();

        // Line 6 edge on the same edge that clears pending[6]: set wins.
        int_lines = 8'h40;
        step();
        int_lines = 8'h00;
        step();
        chk("l6_vec1", 32'(int_vector), 32'h26);
        int_lines = 8'h40;
        int_clear = 1'b1;
        step();
        int_lines = 8'h00;
        int_clear = 1'b0;
        chk("l6_gap_pd", 32'(pending),    32'h40);
        chk("l6_gap_or", 32'(or_int_vec), 32'h0);
        step();
        step();
        chk("l6_rearm_or",  32'(or_int_vec), 32'h1);
        chk("l6_rearm_vec", 32'(int_vector), 32'h26);

        // int_clear outside ARMED is ignored; masked line stays pending only.
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        step();
        chk("clr_idle_or", 32'(or_int_vec), 32'h0);
        line_mask = 8'h80;
        int_lines = 8'h80;
        int_clear = 1'b1;
        step();
        int_lines = 8'h00;
        int_clear = 1'b0;
        step();
        step();
        chk("mask_pd", 32'(pending),    32'h80);
        chk("mask_or", 32'(or_int_vec), 32'h0);
        line_mask = 8'h00;
        step();
        chk("unmask_vec", 32'(int_vector), 32'h27);
        chk("unmask_idt", idt_address,     32'h138);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_request_unit.md
INT_REQUEST_UNIT -- requirements
Module: int_request_unit

Interface
REQ-001 Parameter NUM_LINES, 8, count of hardware interrupt request lines.
REQ-002 Parameter HW_VEC_BASE, 8'h20, vector of line 0; line i uses HW_VEC_BASE+i.
REQ-003 Parameter IDT_BASE, 32'h0000_0000, base byte address of the interrupt descriptor table.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 int_lines  in  NUM_LINES  hardware requests; rising-edge triggered, synchronous to clk.
REQ-007 line_mask  in  NUM_LINES  1 = line blocked from selection; it still records pending.
REQ-008 if_flag  in  1  EFLAGS.IF; 0 blocks all hardware lines from selection.
REQ-009 sw_int_valid  in  1  software INT n request from writeback.
REQ-010 sw_int_vector  in  8  vector for sw_int_valid.
REQ-011 sw_int_ready  out  1  sw request accepted when valid&ready on a clock edge.
REQ-012 int_clear  in  1  single-cycle pulse from int_controller; current interrupt has been serviced.
REQ-013 or_int_vec  out  1  request to int_controller; an interrupt is armed.
REQ-014 int_vector  out  8  armed vector; stable while or_int_vec=1.
REQ-015 idt_address  out  32  IDT_BASE + int_vector*8, modulo 2^32.
REQ-016 pending  out  NUM_LINES  pending hardware bits, for debug.

Function
REQ-017 Edge detect: prev_lines registers int_lines every cycle; pending[i] is set on an edge where int_lines[i]=1 and prev_lines[i]=0.
REQ-018 Software slot: one-entry buffer; sw_int_ready = ~sw_pending; acceptance captures sw_int_vector and sets sw_pending.
REQ-019 Eligibility: sw_pending is always eligible; hardware line i is eligible when pending[i] & ~line_mask[i] & if_flag.
REQ-020 Priority: software slot highest, then lowest-numbered eligible hardware line.
REQ-021 FSM states: IDLE(0), ARMED(1), GAP(2). Encoding value 3 is illegal and returns to IDLE.
REQ-022 IDLE -> ARMED on the first edge where any request is eligible. On that edge, the winning source id and vector are captured.
REQ-023 ARMED: or_int_vec=1 and int_vector/idt_address hold the captured values, ignoring later if_flag, mask or new higher-priority requests.
REQ-024 ARMED -> GAP on int_clear; the captured source's pending bit (or sw_pending) is cleared on the same edge.
REQ-025 GAP -> IDLE unconditionally after one cycle with or_int_vec=0, so int_controller returns to idle before the next request.
REQ-026 In IDLE and GAP, or_int_vec=0; int_vector and idt_address keep the last captured value.
REQ-027 int_clear outside ARMED is ignored.
REQ-028 Same-cycle set and clear of a hardware pending bit: the set wins, and the bit stays 1.
REQ-029 Software acceptance in the same cycle that int_clear frees the software slot: the slot is not ready that cycle, because ready is based on registered sw_pending.
REQ-030 Latency: line edge sampled at edge k -> pending at k -> or_int_vec=1 after edge k+1. A software request accepted at edge k arms at k+1.

Reset
REQ-031 On reset assertion: state=IDLE, pending=0, sw_pending=0, captured vector=0, prev_lines=all ones.
REQ-032 Because prev_lines resets to all ones, a line held high through reset release produces no request until it goes low and then high.
REQ-033 Reset values of outputs: or_int_vec=0, int_vector=0, idt_address=IDT_BASE, sw_int_ready=1, pending=0.
REQ-034 Reset mid-ARMED discards the armed interrupt without requiring int_clear.

Structure
REQ-035 A shared package int_pkg holds: FSM state encoding, NUM_LINES default, HW_VEC_BASE default, and the source-id width/type. The source id distinguishes the software slot from hardware lines.
REQ-036 One sub-module, int_prio_enc, is combinational. Inputs: eligibility vector. Outputs: any-eligible flag and winner index.
REQ-037 All state uses the codebase register primitive with asynchronous reset.

Verification
REQ-038 Pulse int_lines[3] with if_flag=1, mask=0 -> or_int_vec=1 two edges later, int_vector=8'h23, idt_address=IDT_BASE+32'h118.
REQ-039 Raise lines 5 and 2 in the same cycle -> vector 8'h22 armed. After int_clear, a GAP cycle with or_int_vec=0, then 8'h25 armed.
REQ-040 Set pending[1], then sw_int_valid with vector 8'h80 while IDLE -> 8'h80 armed first, and sw_int_ready=0 until cleared. Set if_flag=0 -> line 1 stays pending and is not armed. Set if_flag=1 -> vector 8'h21 is armed.
REQ-041 While ARMED with 8'h24: drop if_flag and raise line 0 -> int_vector stays 8'h24 until int_clear.
REQ-042 Assert reset while ARMED with int_lines[0] held high -> or_int_vec=0 at once. After release, no request until line 0 toggles low then high.
REQ-043 Line 6 edge in the same cycle int_clear clears pending[6] -> pending[6] remains 1, and 8'h26 is re-armed after GAP.
